// File: rtl/vae_batch_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// vae_sched_pkg
// Shared definitions for the VAE batch scheduler slice:
//   - sched_state_t : scheduler FSM encoding (IDLE=0, LOAD=1, RUN=2, DRAIN=3)
//   - DEF_*         : default depths/widths of the forward_vae core buffers
//   - SKID_DEPTH    : entries in the output skid FIFO, SKID_CNT_W its count width
// ---------------------------------------------------------------------------
package vae_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_RUN   = 2'd2,
      ST_DRAIN = 2'd3
   } sched_state_t;

   localparam int DEF_MEM_DEPTH_IN   = 20;
   localparam int DEF_MEM_DEPTH_OUT  = 11;
   localparam int DEF_ADDR_WIDTH_IN  = 5;
   localparam int DEF_ADDR_WIDTH_OUT = 4;
   localparam int DEF_DATA_WIDTH     = 64;

   localparam int SKID_DEPTH = 2;
   localparam int SKID_CNT_W = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/vae_batch_scheduler_if.sv
// ---------------------------------------------------------------------------
// vae_batch_scheduler_if
// AXI4-Stream style channel used for both the sample input and result output.
// Signals: tvalid, tready, tdata[DATA_WIDTH-1:0], tlast.
// Modports:
//   master : drives tvalid/tdata/tlast, receives tready
//   slave  : receives tvalid/tdata/tlast, drives tready
// ---------------------------------------------------------------------------
interface vae_batch_scheduler_if
   import vae_sched_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

   logic                  tvalid;
   logic                  tready;
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tlast;

   modport master (output tvalid, output tdata, output tlast, input tready);
   modport slave  (input tvalid, input tdata, input tlast, output tready);

endinterface

// File: rtl/vae_batch_scheduler_skid_fifo.sv
// ---------------------------------------------------------------------------
// vae_skid_fifo
// Small register FIFO (SKID_DEPTH entries) that decouples core read latency
// from downstream backpressure. The head entry stays stable until popped.
// Ports:
//   clk, reset    : clock and synchronous active-high reset
//   i_push        : write i_pushData this cycle
//   i_pushData    : entry to store
//   o_popValid    : FIFO holds at least one entry
//   i_popReady    : consumer takes the head entry when o_popValid is high
//   o_popData     : head entry
//   o_count       : number of stored entries
// ---------------------------------------------------------------------------
module vae_skid_fifo
   import vae_sched_pkg::*;
#(
   parameter int WIDTH = DEF_DATA_WIDTH + 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_push,
   input  logic [WIDTH-1:0]      i_pushData,
   output logic                  o_popValid,
   input  logic                  i_popReady,
   output logic [WIDTH-1:0]      o_popData,
   output logic [SKID_CNT_W-1:0] o_count
);

   localparam logic [SKID_CNT_W-1:0] FULL_CNT = SKID_CNT_W'(SKID_DEPTH);

   logic [WIDTH-1:0]      r_mem [SKID_DEPTH];
   logic                  r_wrPtr;
   logic                  r_rdPtr;
   logic [SKID_CNT_W-1:0] r_count;
   logic                  w_pop;
   logic                  w_push;

   assign w_pop      = i_popReady && (r_count != '0);
   assign w_push     = i_push && ((r_count != FULL_CNT) || w_pop);
   assign o_popValid = (r_count != '0);
   assign o_popData  = r_mem[r_rdPtr];
   assign o_count    = r_count;

   // Storage, pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < SKID_DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wrPtr <= 1'b0;
         r_rdPtr <= 1'b0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wrPtr] <= i_pushData;
            r_wrPtr        <= ~r_wrPtr;
         end
         if (w_pop) begin
            r_rdPtr <= ~r_rdPtr;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/vae_batch_scheduler.sv
// ---------------------------------------------------------------------------
// vae_batch_scheduler
// Drives the forward_vae core over a batch of samples: loads MEM_DEPTH_IN
// words per sample from s_axis into the core, runs the core until
// core_finish, then streams MEM_DEPTH_OUT result words out on m_axis through
// a 2-entry skid FIFO with full backpressure support.
// Ports:
//   aclk, areset      : clock, synchronous active-high reset
//   cfg_batch_len     : samples per batch (0 treated as 1), latched leaving IDLE
//   s_axis (slave)    : input sample words, tlast on the last word of a sample
//   m_axis (master)   : result words, tlast on the last word of the batch
//   core_start/core_in_addr/core_din : core input buffer write port
//   core_rd_en/core_finish           : core run enable and completion level
//   core_en_out/core_out_addr/core_dout : core output read port (1-cycle latency)
//   busy, batch_done, err_framing    : status (busy, completion pulse, sticky tlast error)
// Optional: define VAE_SCHED_PERF_CNT_EN to add perf_run_cycles[31:0], the
// number of cycles spent in RUN during the current batch.
// ---------------------------------------------------------------------------
module vae_batch_scheduler
   import vae_sched_pkg::*;
#(
   parameter int MEM_DEPTH_IN   = DEF_MEM_DEPTH_IN,
   parameter int MEM_DEPTH_OUT  = DEF_MEM_DEPTH_OUT,
   parameter int ADDR_WIDTH_IN  = DEF_ADDR_WIDTH_IN,
   parameter int ADDR_WIDTH_OUT = DEF_ADDR_WIDTH_OUT,
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH
) (
   input  logic                      aclk,
   input  logic                      areset,
   input  logic [15:0]               cfg_batch_len,
   vae_batch_scheduler_if.slave      s_axis,
   vae_batch_scheduler_if.master     m_axis,
   output logic                      core_start,
   output logic [ADDR_WIDTH_IN-1:0]  core_in_addr,
   output logic [DATA_WIDTH-1:0]     core_din,
   output logic                      core_rd_en,
   input  logic                      core_finish,
   output logic                      core_en_out,
   output logic [ADDR_WIDTH_OUT-1:0] core_out_addr,
   input  logic [DATA_WIDTH-1:0]     core_dout,
   output logic                      busy,
   output logic                      batch_done,
   output logic                      err_framing
`ifdef VAE_SCHED_PERF_CNT_EN
   ,
   output logic [31:0]               perf_run_cycles
`endif
);

   localparam int RD_W = ADDR_WIDTH_OUT + 1;
   localparam int CR_W = SKID_CNT_W + 1;
   localparam logic [ADDR_WIDTH_IN-1:0] WORD_LAST = ADDR_WIDTH_IN'(MEM_DEPTH_IN - 1);
   localparam logic [RD_W-1:0]          RD_LAST   = RD_W'(MEM_DEPTH_OUT - 1);
   localparam logic [RD_W-1:0]          RD_END    = RD_W'(MEM_DEPTH_OUT);

   sched_state_t           r_state;
   logic [ADDR_WIDTH_IN-1:0] r_wordCnt;
   logic [RD_W-1:0]        r_rdCnt;
   logic [15:0]            r_sampleCnt;
   logic [15:0]            r_batchLen;
   logic                   r_sTready;
   logic                   r_coreRdEn;
   logic                   r_busy;
   logic                   r_batchDone;
   logic                   r_errFraming;
   logic                   r_inflight;
   logic                   r_inflightLast;

   logic                   w_inHs;
   logic                   w_wordLast;
   logic                   w_lastSample;
   logic                   w_fifoValid;
   logic [DATA_WIDTH:0]    w_fifoHead;
   logic [SKID_CNT_W-1:0]  w_fifoCount;
   logic                   w_pop;
   logic [CR_W-1:0]        w_credit;
   logic                   w_issue;
   logic                   w_drainDone;

   assign w_inHs       = (r_state == ST_LOAD) && s_axis.tvalid;
   assign w_wordLast   = (r_wordCnt == WORD_LAST);
   assign w_lastSample = (r_sampleCnt == (r_batchLen - 16'd1));
   assign w_pop        = w_fifoValid && m_axis.tready;

   // Slots already claimed by stored or in-flight words; a word leaving this
   // cycle frees its slot so reads can be issued every cycle under full ready.
   assign w_credit    = {1'b0, w_fifoCount} + CR_W'(r_inflight) - CR_W'(w_pop);
   assign w_issue     = (r_state == ST_DRAIN) && (r_rdCnt < RD_END) &&
                        (w_credit < CR_W'(SKID_DEPTH));
   assign w_drainDone = (r_state == ST_DRAIN) && (r_rdCnt == RD_END) &&
                        !r_inflight && (w_fifoCount == '0);

   // Everything is forced to 0 while reset is held, including the cycle
   // before the reset edge is taken.
   assign s_axis.tready = r_sTready && !areset;
   assign core_start    = w_inHs && !areset;
   assign core_in_addr  = areset ? '0 : r_wordCnt;
   assign core_din      = areset ? '0 : s_axis.tdata;
   assign core_rd_en    = r_coreRdEn && !areset;
   assign core_en_out   = w_issue && !areset;
   assign core_out_addr = areset ? '0 : r_rdCnt[ADDR_WIDTH_OUT-1:0];
   assign m_axis.tvalid = w_fifoValid && !areset;
   assign m_axis.tdata  = areset ? '0 : w_fifoHead[DATA_WIDTH-1:0];
   assign m_axis.tlast  = w_fifoValid && w_fifoHead[DATA_WIDTH] && !areset;
   assign busy          = r_busy && !areset;
   assign batch_done    = r_batchDone && !areset;
   assign err_framing   = r_errFraming && !areset;

   // Scheduler FSM; tready, rd_en, busy and batch_done are registered
   // alongside the state so they change on the same edge as the transition.
   always_ff @(posedge aclk) begin
      if (areset) begin
         r_state      <= ST_IDLE;
         r_wordCnt    <= '0;
         r_rdCnt      <= '0;
         r_sampleCnt  <= '0;
         r_batchLen   <= '0;
         r_sTready    <= 1'b0;
         r_coreRdEn   <= 1'b0;
         r_busy       <= 1'b0;
         r_batchDone  <= 1'b0;
         r_errFraming <= 1'b0;
      end else begin
         r_batchDone <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (s_axis.tvalid) begin
                  r_batchLen  <= (cfg_batch_len == 16'd0) ? 16'd1 : cfg_batch_len;
                  r_sampleCnt <= '0;
                  r_wordCnt   <= '0;
                  r_rdCnt     <= '0;
                  r_sTready   <= 1'b1;
                  r_busy      <= 1'b1;
                  r_state     <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               if (w_inHs) begin
                  if (s_axis.tlast != w_wordLast) begin
                     r_errFraming <= 1'b1;
                  end
                  if (w_wordLast) begin
                     r_wordCnt  <= '0;
                     r_sTready  <= 1'b0;
                     r_coreRdEn <= 1'b1;
                     r_state    <= ST_RUN;
                  end else begin
                     r_wordCnt <= r_wordCnt + 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (core_finish) begin
                  r_coreRdEn <= 1'b0;
                  r_state    <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (w_issue) begin
                  r_rdCnt <= r_rdCnt + 1'b1;
               end
               if (w_drainDone) begin
                  r_rdCnt <= '0;
                  if (w_lastSample) begin
                     r_batchDone <= 1'b1;
                     r_busy      <= 1'b0;
                     r_state     <= ST_IDLE;
                  end else begin
                     r_sampleCnt <= r_sampleCnt + 16'd1;
                     r_sTready   <= 1'b1;
                     r_state     <= ST_LOAD;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // One-cycle read pipeline: core_dout becomes valid the cycle after issue,
   // carrying the end-of-batch marker computed at issue time.
   always_ff @(posedge aclk) begin
      if (areset) begin
         r_inflight     <= 1'b0;
         r_inflightLast <= 1'b0;
      end else begin
         r_inflight     <= w_issue;
         r_inflightLast <= w_issue && (r_rdCnt == RD_LAST) && w_lastSample;
      end
   end

   vae_skid_fifo #(
      .WIDTH (DATA_WIDTH + 1)
   ) u_skidFifo (
      .clk        (aclk),
      .reset      (areset),
      .i_push     (r_inflight),
      .i_pushData ({r_inflightLast, core_dout}),
      .o_popValid (w_fifoValid),
      .i_popReady (m_axis.tready),
      .o_popData  (w_fifoHead),
      .o_count    (w_fifoCount)
   );

`ifdef VAE_SCHED_PERF_CNT_EN
   logic [31:0] r_perfRunCycles;

   // RUN-cycle counter for the current batch; restarts when a batch begins
   // and holds after completion.
   always_ff @(posedge aclk) begin
      if (areset) begin
         r_perfRunCycles <= '0;
      end else if ((r_state == ST_IDLE) && s_axis.tvalid) begin
         r_perfRunCycles <= '0;
      end else if (r_state == ST_RUN) begin
         r_perfRunCycles <= r_perfRunCycles + 32'd1;
      end
   end

   assign perf_run_cycles = areset ? '0 : r_perfRunCycles;
`endif

endmodule

// File: tb/tb_vae_batch_scheduler.sv
// ---------------------------------------------------------------------------
// tb_vae_batch_scheduler
// Directed bench for vae_batch_scheduler. Each sample sent pushes its
// expected result words into a queue; a negedge monitor pops and compares
// every accepted output word. A small core model stores written words, raises
// finish after five RUN cycles and returns f(sum of stored words, address).
// ---------------------------------------------------------------------------
module tb_vae_batch_scheduler;

   localparam int DW   = 64;
   localparam int CW   = DW + 1;
   localparam int AWI  = 5;
   localparam int AWO  = 4;
   localparam int NIN  = 20;
   localparam int NOUT = 11;

   logic          aclk = 1'b0;
   logic          areset = 1'b1;
   logic [15:0]   cfgBatchLen = 16'd1;
   logic          coreStart;
   logic [AWI-1:0] coreInAddr;
   logic [DW-1:0] coreDin;
   logic          coreRdEn;
   logic          coreFinish = 1'b0;
   logic          coreEnOut;
   logic [AWO-1:0] coreOutAddr;
   logic [DW-1:0] coreDout = '0;
   logic          busy;
   logic          batchDone;
   logic          errFraming;
`ifdef VAE_SCHED_PERF_CNT_EN
   logic [31:0]   perfRunCycles;
`endif

   vae_batch_scheduler_if #(.DATA_WIDTH(DW)) sAxis ();
   vae_batch_scheduler_if #(.DATA_WIDTH(DW)) mAxis ();

   vae_batch_scheduler dut (
      .aclk          (aclk),
      .areset        (areset),
      .cfg_batch_len (cfgBatchLen),
      .s_axis        (sAxis),
      .m_axis        (mAxis),
      .core_start    (coreStart),
      .core_in_addr  (coreInAddr),
      .core_din      (coreDin),
      .core_rd_en    (coreRdEn),
      .core_finish   (coreFinish),
      .core_en_out   (coreEnOut),
      .core_out_addr (coreOutAddr),
      .core_dout     (coreDout),
      .busy          (busy),
      .batch_done    (batchDone),
      .err_framing   (errFraming)
`ifdef VAE_SCHED_PERF_CNT_EN
      ,
      .perf_run_cycles (perfRunCycles)
`endif
   );

   always #5 aclk = ~aclk;

   int            checks = 0;
   int            errors = 0;
   logic [DW:0]   expQ[$];
   int            popCnt = 0;
   int            doneCnt = 0;
   int            occ = 0;
   int            maxOcc = 0;
   int            wrIdx = 0;
   logic          bpMode = 1'b0;
   logic          stallPending = 1'b0;
   logic [DW-1:0] stallData = '0;
   logic [DW-1:0] coreMem [NIN];
   logic [DW-1:0] runSum = '0;
   int            runCnt = 0;
   logic          prevRdEn = 1'b0;

   // Result word the core model returns for a given input sum and address.
   function automatic logic [DW-1:0] expWord(input logic [DW-1:0] s, input logic [3:0] a);
      return (s << 8) ^ {60'h0, a} ^ 64'hA5A5_0000_0000_0000;
   endfunction

   function automatic logic [DW-1:0] sumMem();
      logic [DW-1:0] acc;
      acc = '0;
      for (int i = 0; i < NIN; i++) acc = acc + coreMem[i];
      return acc;
   endfunction

   function automatic logic outOr();
      return |{sAxis.tready, mAxis.tvalid, mAxis.tdata, mAxis.tlast, coreStart,
               coreInAddr, coreDin, coreRdEn, coreEnOut, coreOutAddr, busy,
               batchDone, errFraming};
   endfunction

   task automatic checkOutput(input string name, input logic [DW:0] act, input logic [DW:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Core model: input buffer, finish after five RUN cycles, 1-cycle read latency.
   always @(posedge aclk) begin
      if (coreStart && (int'(coreInAddr) < NIN)) coreMem[coreInAddr] <= coreDin;
      if (areset || !coreRdEn) begin
         runCnt     <= 0;
         coreFinish <= 1'b0;
      end else begin
         runCnt <= runCnt + 1;
         if (runCnt == 4) coreFinish <= 1'b1;
      end
      if (coreRdEn && !prevRdEn) runSum <= sumMem();
      prevRdEn <= coreRdEn;
      if (coreEnOut) coreDout <= expWord(runSum, coreOutAddr);
   end

   // Output ready driver: random stalls in backpressure mode, else always ready.
   initial begin
      mAxis.tready = 1'b1;
      forever begin
         @(posedge aclk);
         #1;
         mAxis.tready = bpMode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor: scoreboard pops, stall stability, write addresses, outstanding reads.
   always @(negedge aclk) begin
      if (areset) begin
         occ          = 0;
         stallPending = 1'b0;
         wrIdx        = 0;
      end else begin
         if (stallPending) begin
            checkOutput("tvalidHeld", CW'(mAxis.tvalid), CW'(1));
            checkOutput("tdataHeld", CW'(mAxis.tdata), CW'(stallData));
         end
         stallPending = mAxis.tvalid && !mAxis.tready;
         stallData    = mAxis.tdata;
         if (coreStart) begin
            checkOutput("coreInAddr", CW'(coreInAddr), CW'(wrIdx));
            wrIdx = (wrIdx == NIN - 1) ? 0 : wrIdx + 1;
         end
         if (mAxis.tvalid && mAxis.tready) begin
            if (expQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpectedWord actual=%h expected=none", {mAxis.tlast, mAxis.tdata});
            end else begin
               checkOutput("outWord", {mAxis.tlast, mAxis.tdata}, expQ.pop_front());
            end
            popCnt++;
         end
         occ = occ + int'(coreEnOut) - int'(mAxis.tvalid && mAxis.tready);
         if (occ > maxOcc) maxOcc = occ;
         if (batchDone) doneCnt++;
      end
   end

   // Send one sample of NIN words; tlast on word tlastIdx; queue its expected results.
   task automatic applyStimulus(input logic [DW-1:0] base, input int tlastIdx, input bit lastOfBatch);
      logic [DW-1:0] sum;
      int            t;
      sum = '0;
      for (int i = 0; i < NIN; i++) sum = sum + base + DW'(i);
      for (int a = 0; a < NOUT; a++) begin
         expQ.push_back({(lastOfBatch && (a == NOUT - 1)), expWord(sum, 4'(a))});
      end
      for (int i = 0; i < NIN; i++) begin
         sAxis.tvalid = 1'b1;
         sAxis.tdata  = base + DW'(i);
         sAxis.tlast  = (i == tlastIdx);
         t = 0;
         while (!sAxis.tready && t < 2000) begin
            @(posedge aclk);
            #1;
            t++;
         end
         if (!sAxis.tready) begin
            checkOutput("inputHandshakeTimeout", CW'(0), CW'(1));
            break;
         end
         @(posedge aclk);
         #1;
      end
      sAxis.tvalid = 1'b0;
      sAxis.tlast  = 1'b0;
   endtask

   task automatic waitBatchDone(input int d0);
      int t;
      t = 0;
      while (doneCnt == d0 && t < 3000) begin
         @(posedge aclk);
         #1;
         t++;
      end
      repeat (3) begin
         @(posedge aclk);
         #1;
      end
      checkOutput("batchDonePulses", CW'(doneCnt - d0), CW'(1));
      checkOutput("scoreboardDrained", CW'(expQ.size()), CW'(0));
      checkOutput("idleAfterBatch", CW'(busy), CW'(0));
   endtask

   task automatic runBatch(input int n, input logic [15:0] cfg, input logic [DW-1:0] base, input int tlastIdx);
      int d0;
      d0 = doneCnt;
      cfgBatchLen = cfg;
      for (int s = 0; s < n; s++) begin
         applyStimulus(base + DW'(s * 256), tlastIdx, (s == n - 1));
      end
      waitBatchDone(d0);
   endtask

   initial begin
      int d0;
      int p0;
      int t;
      sAxis.tvalid = 1'b0;
      sAxis.tdata  = '0;
      sAxis.tlast  = 1'b0;
      areset       = 1'b1;
      repeat (3) @(posedge aclk);
      #1;
      checkOutput("resetOutputsZero", CW'(outOr()), CW'(0));
      areset = 1'b0;
      @(posedge aclk);
      #1;

      $display("[TB] single sample, words 0x1..0x14");
      runBatch(1, 16'd1, 64'h1, NIN - 1);
`ifdef VAE_SCHED_PERF_CNT_EN
      checkOutput("perfRunCycles1", CW'(perfRunCycles), CW'(6));
`endif

      $display("[TB] batch of 3, cfg changed mid-batch");
      d0 = doneCnt;
      cfgBatchLen = 16'd3;
      applyStimulus(64'h100, NIN - 1, 1'b0);
      cfgBatchLen = 16'd1;
      checkOutput("busyMidBatch", CW'(busy), CW'(1));
      applyStimulus(64'h200, NIN - 1, 1'b0);
      applyStimulus(64'h300, NIN - 1, 1'b1);
      waitBatchDone(d0);

      $display("[TB] random backpressure, batch of 2");
      bpMode = 1'b1;
      maxOcc = 0;
      runBatch(2, 16'd2, 64'h1000, NIN - 1);
      bpMode = 1'b0;
      checkOutput("maxOutstandingLe2", CW'(maxOcc <= 2), CW'(1));
      checkOutput("noFramingErrYet", CW'(errFraming), CW'(0));

      $display("[TB] framing error, tlast on word 19");
      runBatch(1, 16'd1, 64'h2000, NIN - 2);
      checkOutput("errFramingSticky", CW'(errFraming), CW'(1));

      $display("[TB] reset during DRAIN");
      d0 = doneCnt;
      p0 = popCnt;
      cfgBatchLen = 16'd1;
      applyStimulus(64'h3000, NIN - 1, 1'b1);
      t = 0;
      while (popCnt < p0 + 4 && t < 2000) begin
         @(posedge aclk);
         #1;
         t++;
      end
      checkOutput("reachedDrainPops", CW'(popCnt >= p0 + 4), CW'(1));
      areset = 1'b1;
      expQ.delete();
      @(posedge aclk);
      #1;
      checkOutput("midResetOutputsZero", CW'(outOr()), CW'(0));
      checkOutput("errClearedByReset", CW'(errFraming), CW'(0));
      areset = 1'b0;
      repeat (2) begin
         @(posedge aclk);
         #1;
      end
      checkOutput("noBatchDoneOnReset", CW'(doneCnt - d0), CW'(0));
      checkOutput("idleAfterReset", CW'(busy), CW'(0));

      $display("[TB] clean batch after reset");
      runBatch(1, 16'd1, 64'h4000, NIN - 1);
      checkOutput("noFramingErrAfterReset", CW'(errFraming), CW'(0));

      $display("[TB] cfg_batch_len 0 behaves as 1");
      runBatch(1, 16'd0, 64'h5000, NIN - 1);
`ifdef VAE_SCHED_PERF_CNT_EN
      checkOutput("perfRunCyclesLen0", CW'(perfRunCycles), CW'(6));
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired actual=running required=finished");
      $fatal(1, "[TB] watchdog");
   end

endmodule
